// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB master bridge.
package apb_pkg;

    localparam int unsigned DEFAULT_ADDR_WIDTH     = 32;
    localparam int unsigned DEFAULT_DATA_WIDTH     = 32;
    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;
    localparam int unsigned TIMER_WIDTH            = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/apb_master_bridge_if.sv
// Command/response handshake plus APB bus signals seen by the bridge.
interface apb_master_bridge_if
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    // Command side
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // Response side
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB side
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic                  PSEL;
    logic                  PENABLE;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    // The bridge itself
    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  PRDATA, PREADY, PSLVERR,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output PADDR, PWRITE, PWDATA, PSEL, PENABLE
    );

    // Requester plus APB completer, i.e. everything around the bridge
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output PRDATA, PREADY, PSLVERR,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  PADDR, PWRITE, PWDATA, PSEL, PENABLE
    );

endinterface

// File: rtl/apb_timeout_timer.sv
// Wait-state counter for the ACCESS phase; flags the cycle that reaches the limit.
module apb_timeout_timer
    import apb_pkg::*;
#(
    parameter int unsigned WIDTH = TIMER_WIDTH
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH:0]   count_inc;

    // Extra bit keeps the compare honest when the limit sits at the top of the range.
    assign count_inc = {1'b0, count_q} + ONE;

    // Expires on the stalled cycle that would bring the count up to the limit.
    assign expired = enable && (count_inc >= {1'b0, limit});

    // Count stalled ACCESS cycles; restart ahead of every ACCESS phase.
    always_ff @(posedge PCLK) begin
        if (PRESET || clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_inc[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding command/response to APB master bridge with wait-state timeout.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                PCLK,
    input  logic                PRESET,
    apb_master_bridge_if.master bus
);

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LIMIT = TIMER_WIDTH'(TIMEOUT_CYCLES);

    apb_state_e state_q, state_d;

    logic                  cmd_ready_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;

    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    apb_timeout_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_timer (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .limit   (TIMEOUT_LIMIT),
        .expired (timer_expired)
    );

    // Next-state decode; PREADY takes priority over expiry in ACCESS.
    always_comb begin
        state_d      = state_q;
        timer_clear  = (state_q == SETUP);
        timer_enable = (state_q == ACCESS) && !bus.PREADY;
        unique case (state_q)
            IDLE:    if (bus.cmd_valid && cmd_ready_q) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.PREADY || timer_expired) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cmd_ready_q   <= 1'b1;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            cmd_ready_q <= (state_d == IDLE);
            psel_q      <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q   <= (state_d == ACCESS);
            rsp_valid_q <= (state_d == RESP);

            // Request fields only move on an accepted command.
            if ((state_q == IDLE) && bus.cmd_valid && cmd_ready_q) begin
                paddr_q  <= bus.cmd_addr;
                pwrite_q <= bus.cmd_write;
                pwdata_q <= bus.cmd_wdata;
            end

            if (state_q == ACCESS) begin
                if (bus.PREADY) begin
                    rsp_rdata_q   <= pwrite_q ? '0 : bus.PRDATA;
                    rsp_err_q     <= bus.PSLVERR;
                    rsp_timeout_q <= 1'b0;
                end else if (timer_expired) begin
                    rsp_rdata_q   <= '0;
                    rsp_err_q     <= 1'b1;
                    rsp_timeout_q <= 1'b1;
                end
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.PSEL        = psel_q;
    assign bus.PENABLE     = penable_q;
    assign bus.PWRITE      = pwrite_q;
    assign bus.PADDR       = paddr_q;
    assign bus.PWDATA      = pwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule
